// File: rtl/sobel_frame_responder_pkg.sv
// Shared types for the Sobel frame buffer responder.
// Bus field widths and the transaction FSM encoding.
package sobel_frame_responder_pkg;
  localparam int DATA_W  = 32;
  localparam int BURST_W = 8;
  localparam int BE_W    = 4;
  localparam int REM_W   = BURST_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_ERROR
  } state_t;
endpackage

// File: rtl/sobel_frame_responder_if.sv
// Burst bus between the Sobel initiator and the frame buffer.
// Names are from the responder's point of view (In = to responder).
interface sobel_frame_responder_if;
  import sobel_frame_responder_pkg::*;

  logic               beginTransactionIn;
  logic [DATA_W-1:0]  addressDataIn;
  logic               readNotWriteIn;
  logic [BURST_W-1:0] burstSizeIn;
  logic [BE_W-1:0]    byteEnablesIn;
  logic               dataValidIn;
  logic               endTransactionIn;
  logic               busyIn;
  logic [DATA_W-1:0]  addressDataOut;
  logic               dataValidOut;
  logic               endTransactionOut;
  logic               busyOut;
  logic               busErrorOut;

  modport master (
    output beginTransactionIn, addressDataIn, readNotWriteIn,
    output burstSizeIn, byteEnablesIn, dataValidIn,
    output endTransactionIn, busyIn,
    input  addressDataOut, dataValidOut, endTransactionOut,
    input  busyOut, busErrorOut
  );

  modport slave (
    input  beginTransactionIn, addressDataIn, readNotWriteIn,
    input  burstSizeIn, byteEnablesIn, dataValidIn,
    input  endTransactionIn, busyIn,
    output addressDataOut, dataValidOut, endTransactionOut,
    output busyOut, busErrorOut
  );
endinterface

// File: rtl/sobel_frame_ram.sv
// Frame buffer RAM: byte-enable write, registered reads.
// Port A (bus/clear) has its own read address so reads never stall on clear.
module sobel_frame_ram
  import sobel_frame_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_ren,
  input  logic [ADDR_WIDTH-1:0] a_raddr,
  output logic [DATA_W-1:0]     a_rdata,
  input  logic [BE_W-1:0]       a_we,
  input  logic [ADDR_WIDTH-1:0] a_waddr,
  input  logic [DATA_W-1:0]     a_wdata,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_W-1:0]     b_rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  always_comb begin
    a_rdata_d = a_rdata_q;
    if (a_ren) a_rdata_d = mem_q[a_raddr];
    b_rdata_d = mem_q[b_addr];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (a_we[i]) mem_q[a_waddr][8*i +: 8] <= a_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
endmodule

// File: rtl/sobel_frame_responder.sv
// Bus responder for the Sobel frame buffer with clear engine
// and a local read port for the motion detector.
module sobel_frame_responder
  import sobel_frame_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int          ADDR_WIDTH   = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  sobel_frame_responder_if.slave bus,
  input  logic                  clearStart,
  output logic                  clearBusy,
  input  logic [ADDR_WIDTH-1:0] localAddress,
  output logic [DATA_W-1:0]     localData
);
  localparam int TAG_LSB = ADDR_WIDTH + 2;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [REM_W-1:0]      iss_q, iss_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic                  ram_vld_q, ram_vld_d;
  logic                  dv_q, dv_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  end_q, end_d;
  logic                  clr_busy_q, clr_busy_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;

  logic                  a_ren;
  logic [ADDR_WIDTH-1:0] a_raddr;
  logic [DATA_W-1:0]     a_rdata;
  logic [BE_W-1:0]       a_we;
  logic [ADDR_WIDTH-1:0] a_waddr;
  logic [DATA_W-1:0]     a_wdata;

  logic                  sel;
  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH:0]   span;
  logic [REM_W-1:0]      beats;
  logic                  busy_out;
  logic                  advance;
  logic                  unused_bits;

  assign sel = bus.beginTransactionIn &&
    (bus.addressDataIn[31:TAG_LSB] == BASE_ADDRESS[31:TAG_LSB]);
  assign off   = bus.addressDataIn[TAG_LSB-1:2];
  assign span  = {1'b0, off} + (ADDR_WIDTH+1)'(bus.burstSizeIn);
  assign beats = REM_W'(bus.burstSizeIn) + REM_W'(1);
  assign busy_out = (state_q == ST_WRITE) && clr_busy_q;
  // Read pipeline freezes only while a presented beat is refused.
  assign advance = !(dv_q && bus.busyIn);
  assign unused_bits = ^bus.addressDataIn[1:0];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    iss_d     = iss_q;
    be_d      = be_q;
    ram_vld_d = ram_vld_q;
    dv_d      = dv_q;
    rdata_d   = rdata_q;
    end_d     = 1'b0;
    a_ren     = 1'b0;
    a_raddr   = ptr_q;
    a_we      = '0;
    a_waddr   = ptr_q;
    a_wdata   = bus.addressDataIn;
    unique case (state_q)
      ST_IDLE: begin
        if (sel) begin
          ptr_d = off;
          rem_d = beats;
          be_d  = bus.byteEnablesIn;
          dv_d  = 1'b0;
          if (span[ADDR_WIDTH]) begin
            state_d = ST_ERROR;
          end else if (bus.readNotWriteIn) begin
            state_d   = ST_READ;
            a_ren     = 1'b1;
            a_raddr   = off;
            ptr_d     = off + ADDR_WIDTH'(1);
            iss_d     = beats - REM_W'(1);
            ram_vld_d = 1'b1;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (bus.dataValidIn && !busy_out && rem_q != '0) begin
          a_we  = be_q;
          ptr_d = ptr_q + ADDR_WIDTH'(1);
          rem_d = rem_q - REM_W'(1);
        end
        if (bus.endTransactionIn) state_d = ST_IDLE;
      end
      ST_READ: begin
        if (advance) begin
          a_ren     = (iss_q != '0);
          ram_vld_d = a_ren;
          if (a_ren) begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
            iss_d = iss_q - REM_W'(1);
          end
          dv_d = ram_vld_q;
          if (ram_vld_q) rdata_d = a_rdata;
          if (dv_q) begin
            rem_d = rem_q - REM_W'(1);
            if (rem_q == REM_W'(1)) begin
              dv_d    = 1'b0;
              end_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    clr_busy_d = clr_busy_q;
    clr_ptr_d  = clr_ptr_q;
    if (clearStart) begin
      clr_busy_d = 1'b1;
      clr_ptr_d  = '0;
    end else if (clr_busy_q) begin
      clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
      if (&clr_ptr_q) clr_busy_d = 1'b0;
    end
    // busyOut keeps bus writes off port A while clearing.
    if (clr_busy_q) begin
      a_we    = '1;
      a_waddr = clr_ptr_q;
      a_wdata = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      iss_q      <= '0;
      be_q       <= '0;
      ram_vld_q  <= 1'b0;
      dv_q       <= 1'b0;
      rdata_q    <= '0;
      end_q      <= 1'b0;
      clr_busy_q <= 1'b0;
      clr_ptr_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      iss_q      <= iss_d;
      be_q       <= be_d;
      ram_vld_q  <= ram_vld_d;
      dv_q       <= dv_d;
      rdata_q    <= rdata_d;
      end_q      <= end_d;
      clr_busy_q <= clr_busy_d;
      clr_ptr_q  <= clr_ptr_d;
    end
  end

  sobel_frame_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk     (clock),
    .rst     (reset),
    .a_ren   (a_ren),
    .a_raddr (a_raddr),
    .a_rdata (a_rdata),
    .a_we    (a_we),
    .a_waddr (a_waddr),
    .a_wdata (a_wdata),
    .b_addr  (localAddress),
    .b_rdata (localData)
  );

  assign bus.addressDataOut    = rdata_q;
  assign bus.dataValidOut      = dv_q;
  assign bus.endTransactionOut = end_q || (state_q == ST_ERROR);
  assign bus.busErrorOut       = (state_q == ST_ERROR);
  assign bus.busyOut           = busy_out;
  assign clearBusy             = clr_busy_q;
endmodule

// File: tb/tb_sobel_frame_responder.sv
// Randomized bench for sobel_frame_responder against
// a word-array model of the frame buffer.
module tb_sobel_frame_responder;
  localparam logic [31:0] BASE = 32'h5000_0000;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          clearStart = 1'b0;
  logic          clearBusy;
  logic [AW-1:0] localAddress = '0;
  logic [31:0]   localData;

  sobel_frame_responder_if bus_if();

  sobel_frame_responder #(.BASE_ADDRESS(BASE), .ADDR_WIDTH(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus_if),
    .clearStart   (clearStart),
    .clearBusy    (clearBusy),
    .localAddress (localAddress),
    .localData    (localData)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad = 0;
  logic [31:0] ref_mem [DEPTH];
  int          clr_cycles = 0;
  bit          saw_busy;

  always @(negedge clock) if (clearBusy) clr_cycles++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic mem_wr(input int w, input logic [3:0] be,
                        input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic start(input logic [31:0] addr, input bit rnw,
                       input int burst, input logic [3:0] be);
    bus_if.beginTransactionIn = 1'b1;
    bus_if.addressDataIn      = addr;
    bus_if.readNotWriteIn     = rnw;
    bus_if.burstSizeIn        = 8'(burst);
    bus_if.byteEnablesIn      = be;
    tick;
    bus_if.beginTransactionIn = 1'b0;
    bus_if.readNotWriteIn     = 1'b0;
  endtask

  task automatic bus_write(input int off, input int burst,
                           input logic [3:0] be, input int extra,
                           input bit gaps, input bit rnd,
                           input logic [31:0] seed);
    int n = burst + 1;
    int sent = 0;
    int budget = 0;
    logic [31:0] d;
    start(BASE + 32'(off * 4), 1'b0, burst, be);
    while (sent < n + extra && budget < 3000) begin
      if (gaps && $urandom_range(3) == 0) begin
        bus_if.dataValidIn = 1'b0;
        tick;
        budget++;
      end else begin
        d = rnd ? $urandom : seed + 32'(sent);
        bus_if.dataValidIn   = 1'b1;
        bus_if.addressDataIn = d;
        while (bus_if.busyOut && budget < 3000) begin
          saw_busy = 1'b1;
          tick;
          budget++;
        end
        if (sent < n) mem_wr(off + sent, be, d);
        sent++;
        tick;
        budget++;
      end
    end
    bus_if.dataValidIn      = 1'b0;
    bus_if.endTransactionIn = 1'b1;
    tick;
    bus_if.endTransactionIn = 1'b0;
    chk("wr_budget", 32'(budget < 3000), 1);
  endtask

  // mode 0: never stall, 1: stall beats 3..5 twice each, 2: random
  task automatic bus_read(input int off, input int burst, input int mode);
    int n = burst + 1;
    int k = 0;
    int cyc = 0;
    int lat = -1;
    int stall = 0;
    bit ended = 1'b0;
    bit held = 1'b0;
    bit busy;
    logic [31:0] prev = '0;
    start(BASE + 32'(off * 4), 1'b1, burst, 4'hF);
    cyc = 1;
    while (!ended && cyc < 1000) begin
      busy = 1'b0;
      if (held) begin
        chk("rd_hold_data", bus_if.addressDataOut, prev);
        chk("rd_hold_valid", bus_if.dataValidOut, 1);
      end
      if (bus_if.endTransactionOut) begin
        ended = 1'b1;
        chk("rd_beats", k, n);
        chk("rd_end_dv", bus_if.dataValidOut, 0);
        held = 1'b0;
      end else if (bus_if.dataValidOut) begin
        if (lat < 0) begin
          lat = cyc;
          chk("rd_latency", cyc, 2);
        end
        if (mode == 1) busy = (k >= 3 && k <= 5 && stall < 2);
        if (mode == 2) busy = ($urandom_range(2) == 0);
        if (busy) stall++;
        else begin
          chk("rd_data", bus_if.addressDataOut, ref_mem[off + k]);
          k++;
          stall = 0;
        end
        held = busy;
        prev = bus_if.addressDataOut;
      end else begin
        if (lat >= 0) chk("rd_gap", bus_if.dataValidOut, 1);
        if (mode == 2) busy = ($urandom_range(2) == 0);
        held = 1'b0;
      end
      bus_if.busyIn = busy;
      tick;
      cyc++;
    end
    bus_if.busyIn = 1'b0;
    chk("rd_ended", 32'(ended), 1);
    chk("rd_end_pulse", bus_if.endTransactionOut, 0);
    chk("rd_after_dv", bus_if.dataValidOut, 0);
  endtask

  task automatic bus_err(input int off, input int burst, input bit rnw);
    start(BASE + 32'(off * 4), rnw, burst, 4'hF);
    chk("err_flag", bus_if.busErrorOut, 1);
    chk("err_end", bus_if.endTransactionOut, 1);
    chk("err_dv", bus_if.dataValidOut, 0);
    tick;
    chk("err_flag_off", bus_if.busErrorOut, 0);
    chk("err_end_off", bus_if.endTransactionOut, 0);
  endtask

  initial begin
    int c0;
    bus_if.beginTransactionIn = 1'b0;
    bus_if.addressDataIn      = '0;
    bus_if.readNotWriteIn     = 1'b0;
    bus_if.burstSizeIn        = '0;
    bus_if.byteEnablesIn      = '0;
    bus_if.dataValidIn        = 1'b0;
    bus_if.endTransactionIn   = 1'b0;
    bus_if.busyIn             = 1'b0;
    #1 reset = 1'b1;
    repeat (2) tick;
    chk("rst_dv", bus_if.dataValidOut, 0);
    chk("rst_end", bus_if.endTransactionOut, 0);
    chk("rst_busy", bus_if.busyOut, 0);
    chk("rst_err", bus_if.busErrorOut, 0);
    chk("rst_data", bus_if.addressDataOut, 0);
    chk("rst_clr", clearBusy, 0);
    chk("rst_local", localData, 0);
    reset = 1'b0;
    tick;

    // clear, restart after 100 cycles, read and write during clear
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    c0 = clr_cycles;
    clearStart = 1'b1;
    tick;
    clearStart = 1'b0;
    chk("clr_busy", clearBusy, 1);
    repeat (99) tick;
    clearStart = 1'b1;
    tick;
    clearStart = 1'b0;
    bus_read(0, 1, 0);
    saw_busy = 1'b0;
    bus_write(128, 3, 4'hF, 0, 1'b0, 1'b1, '0);
    chk("clr_saw_busy", 32'(saw_busy), 1);
    chk("clr_cycles", clr_cycles - c0, 1124);
    chk("clr_done", clearBusy, 0);
    bus_read(124, 7, 0);

    // reset aborts a running clear
    clearStart = 1'b1;
    tick;
    clearStart = 1'b0;
    repeat (3) tick;
    reset = 1'b1;
    #1;
    chk("abort_clr", clearBusy, 0);
    tick;
    reset = 1'b0;
    tick;

    bus_write(4, 0, 4'hF, 0, 1'b0, 1'b0, 32'hDEADBEEF);
    bus_read(4, 0, 0);

    bus_write(64, 7, 4'hF, 0, 1'b0, 1'b1, '0);
    bus_read(64, 7, 1);

    bus_write(200, 0, 4'hF, 0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    bus_write(200, 0, 4'b0011, 0, 1'b0, 1'b0, 32'h1234_5678);
    bus_read(200, 0, 0);
    localAddress = AW'(200);
    tick;
    chk("local_be", localData, 32'hFFFF_5678);

    bus_write(1022, 1, 4'hF, 0, 1'b0, 1'b1, '0);
    bus_err(1022, 3, 1'b0);
    bus_err(1022, 3, 1'b1);
    bus_read(1022, 1, 0);
    bus_write(1023, 0, 4'hF, 0, 1'b0, 1'b1, '0);
    bus_read(1023, 0, 0);

    // unselected window: no response, no write
    start(32'h4000_0000, 1'b1, 0, 4'hF);
    repeat (3) begin
      chk("unsel_dv", bus_if.dataValidOut, 0);
      chk("unsel_end", bus_if.endTransactionOut, 0);
      chk("unsel_err", bus_if.busErrorOut, 0);
      tick;
    end
    start(32'h4000_0000, 1'b0, 0, 4'hF);
    bus_if.dataValidIn   = 1'b1;
    bus_if.addressDataIn = 32'hA5A5_A5A5;
    tick;
    bus_if.dataValidIn      = 1'b0;
    bus_if.endTransactionIn = 1'b1;
    tick;
    bus_if.endTransactionIn = 1'b0;
    bus_read(0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      int off;
      int burst;
      off = ($urandom_range(3) == 0) ? $urandom_range(DEPTH - 1, DEPTH - 20)
                                     : $urandom_range(DEPTH - 1);
      burst = $urandom_range(15);
      if (off + burst > DEPTH - 1) begin
        bus_err(off, burst, 1'($urandom_range(1)));
      end else if ($urandom_range(1) == 1) begin
        bus_read(off, burst, 2);
      end else begin
        bus_write(off, burst, 4'($urandom_range(15)),
                  $urandom_range(2), 1'b1, 1'b1, '0);
        bus_read(off, burst, 2);
      end
      localAddress = AW'($urandom_range(DEPTH - 1));
      tick;
      chk("local_rnd", localData, ref_mem[localAddress]);
    end

    // reset during a read burst
    bus_write(300, 15, 4'hF, 0, 1'b0, 1'b1, '0);
    start(BASE + 32'(300 * 4), 1'b1, 15, 4'hF);
    repeat (2) tick;
    chk("mid_rd_pre", bus_if.dataValidOut, 1);
    reset = 1'b1;
    #1;
    chk("mid_rd_dv", bus_if.dataValidOut, 0);
    chk("mid_rd_end", bus_if.endTransactionOut, 0);
    tick;
    reset = 1'b0;
    tick;
    bus_read(305, 0, 0);

    // reset during a write burst keeps accepted beats
    start(BASE + 32'(400 * 4), 1'b0, 7, 4'hF);
    for (int i = 0; i < 3; i++) begin
      bus_if.dataValidIn   = 1'b1;
      bus_if.addressDataIn = 32'hC0DE_0000 + 32'(i);
      mem_wr(400 + i, 4'hF, bus_if.addressDataIn);
      tick;
    end
    bus_if.dataValidIn = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_wr_busy", bus_if.busyOut, 0);
    tick;
    reset = 1'b0;
    tick;
    bus_read(400, 7, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
